// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, widths and
// the default data-memory timeout.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int DATA_W          = 32;
  localparam int REG_W           = 5;
  localparam int CNT_W           = 4;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_buffer4.sv
// MEM/WB pipeline register (buffer4). A bubble clears the write-back controls
// and leaves the data fields holding their previous contents.
module buffer4
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              rd_we,
  input  logic              mem_reg_in,
  input  logic              reg_write_in,
  input  logic [DATA_W-1:0] rd_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [REG_W-1:0]  mux_in,
  output logic              mem_reg_out,
  output logic              reg_write_out,
  output logic [DATA_W-1:0] rd_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [REG_W-1:0]  mux_out
);

  logic              mem_reg_q, mem_reg_d;
  logic              reg_write_q, reg_write_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [REG_W-1:0]  mux_q, mux_d;

  always_comb begin
    mem_reg_d   = mem_reg_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    mux_d       = mux_q;
    if (bubble) begin
      mem_reg_d   = 1'b0;
      reg_write_d = 1'b0;
    end else begin
      mem_reg_d   = mem_reg_in;
      reg_write_d = reg_write_in;
      alu_d       = alu_in;
      mux_d       = mux_in;
      // Load data only moves when a memory access completes.
      if (rd_we) begin
        rd_d = rd_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_reg_q   <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      alu_q       <= '0;
      mux_q       <= '0;
    end else begin
      mem_reg_q   <= mem_reg_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      mux_q       <= mux_d;
    end
  end

  assign mem_reg_out   = mem_reg_q;
  assign reg_write_out = reg_write_q;
  assign rd_out        = rd_q;
  assign alu_out       = alu_q;
  assign mux_out       = mux_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, data-memory handshake with timeout,
// misalignment detection and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INMemREG,
  input  logic        INRegWRITE,
  input  logic        INBranch,
  input  logic        INMemWRITE,
  input  logic        INMemRead,
  input  logic [31:0] inputAdd,
  input  logic [31:0] inputAddrst,
  input  logic [31:0] inputRD2,
  input  logic        Z_flag,
  input  logic [4:0]  inputmux,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic        OTMemREG,
  output logic        OTRegWRITE,
  output logic [31:0] outputRD,
  output logic [31:0] outputAlu,
  output logic [4:0]  outputmux,
  output logic        mem_err
);

  // Last BUSY count value before abort; the counter is CNT_W bits wide, so
  // TIMEOUT must not exceed 2**CNT_W.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;

  logic mem_access;
  logic mem_op;
  logic misaligned;
  logic busy;
  logic bubble;
  logic rd_we;

  assign busy = (state_q == BUSY);

  always_comb begin
    mem_access = INMemRead | INMemWRITE;
    mem_op     = mem_access & word_aligned(inputAddrst[1:0]);
    misaligned = mem_access & ~word_aligned(inputAddrst[1:0]);

    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = 1'b0;
    stall     = 1'b0;
    bubble    = 1'b0;
    rd_we     = 1'b0;

    if (state_q == IDLE) begin
      if (mem_op) begin
        stall   = 1'b1;
        bubble  = 1'b1;
        state_d = BUSY;
        cnt_d   = '0;
      end else if (misaligned) begin
        // Dropped access: no request, no stall, just an error pulse.
        bubble    = 1'b1;
        mem_err_d = 1'b1;
      end
    end else begin
      stall  = ~dm_ack;
      bubble = ~dm_ack;
      if (dm_ack) begin
        rd_we   = 1'b1;
        state_d = IDLE;
      end else if (cnt_q == CNT_LAST) begin
        state_d   = IDLE;
        mem_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Request fields come straight from the held EX/MEM inputs while BUSY.
  assign dm_req        = busy;
  assign dm_we         = busy & INMemWRITE;
  assign dm_addr       = busy ? inputAddrst : '0;
  assign dm_wdata      = busy ? inputRD2 : '0;
  assign PCSrc         = INBranch & Z_flag;
  assign branch_target = inputAdd;
  assign mem_err       = mem_err_q;

  buffer4 u_mem_wb (
    .clk           (clk),
    .rst           (rst),
    .bubble        (bubble),
    .rd_we         (rd_we),
    .mem_reg_in    (INMemREG),
    .reg_write_in  (INRegWRITE),
    .rd_in         (dm_rdata),
    .alu_in        (inputAddrst),
    .mux_in        (inputmux),
    .mem_reg_out   (OTMemREG),
    .reg_write_out (OTRegWRITE),
    .rd_out        (outputRD),
    .alu_out       (outputAlu),
    .mux_out       (outputmux)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage with a transaction-level
// reference model of the MEM/WB results.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        INMemREG, INRegWRITE, INBranch, INMemWRITE, INMemRead;
  logic [31:0] inputAdd, inputAddrst, inputRD2;
  logic        Z_flag;
  logic [4:0]  inputmux;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        stall, PCSrc;
  logic [31:0] branch_target;
  logic        OTMemREG, OTRegWRITE;
  logic [31:0] outputRD, outputAlu;
  logic [4:0]  outputmux;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_regw, exp_memreg, exp_err;
  logic [31:0] exp_rd, exp_alu;
  logic [4:0]  exp_mux;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .INMemREG(INMemREG), .INRegWRITE(INRegWRITE), .INBranch(INBranch),
    .INMemWRITE(INMemWRITE), .INMemRead(INMemRead),
    .inputAdd(inputAdd), .inputAddrst(inputAddrst), .inputRD2(inputRD2),
    .Z_flag(Z_flag), .inputmux(inputmux),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
    .OTMemREG(OTMemREG), .OTRegWRITE(OTRegWRITE), .outputRD(outputRD),
    .outputAlu(outputAlu), .outputmux(outputmux), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic regw, input logic memreg, input logic br,
                        input logic memw, input logic memr, input logic z,
                        input logic [31:0] add, input logic [31:0] addr,
                        input logic [31:0] rd2, input logic [4:0] mux);
    INRegWRITE  = regw;
    INMemREG    = memreg;
    INBranch    = br;
    INMemWRITE  = memw;
    INMemRead   = memr;
    Z_flag      = z;
    inputAdd    = add;
    inputAddrst = addr;
    inputRD2    = rd2;
    inputmux    = mux;
  endtask

  task automatic chk_wb(input string tag);
    chk1({tag, ".OTRegWRITE"}, OTRegWRITE, exp_regw);
    chk1({tag, ".OTMemREG"}, OTMemREG, exp_memreg);
    chk32({tag, ".outputRD"}, outputRD, exp_rd);
    chk32({tag, ".outputAlu"}, outputAlu, exp_alu);
    chk32({tag, ".outputmux"}, 32'(outputmux), 32'(exp_mux));
    chk1({tag, ".mem_err"}, mem_err, exp_err);
  endtask

  // One instruction through the stage. ack_k is the BUSY cycle index (0 =
  // first BUSY cycle) on which memory acknowledges; ack_k >= TIMEOUT means never.
  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_txn(input string tag, input int ack_k, input logic [31:0] ack_data);
    logic        is_mem, is_mis, acked;
    logic [31:0] got_data;
    int          n;
    is_mem   = (INMemRead || INMemWRITE) && (inputAddrst % 4 == 0);
    is_mis   = (INMemRead || INMemWRITE) && (inputAddrst % 4 != 0);
    acked    = is_mem && (ack_k < TIMEOUT);
    got_data = '0;
    n = !is_mem ? 1 : (acked ? ack_k + 2 : TIMEOUT + 1);
    for (int c = 0; c < n; c++) begin
      if (c == 0) dm_ack = 1'($urandom_range(0, 1));
      else        dm_ack = (c - 1 == ack_k);
      dm_rdata = (c > 0 && dm_ack) ? ack_data : $urandom;
      #1;
      chk1({tag, ".stall"}, stall, is_mem && !(c > 0 && c - 1 == ack_k));
      chk1({tag, ".dm_req"}, dm_req, is_mem && c > 0);
      chk1({tag, ".PCSrc"}, PCSrc, INBranch && Z_flag);
      chk32({tag, ".branch_target"}, branch_target, inputAdd);
      if (is_mem && c > 0) begin
        chk1({tag, ".dm_we"}, dm_we, INMemWRITE);
        chk32({tag, ".dm_addr"}, dm_addr, inputAddrst);
        chk32({tag, ".dm_wdata"}, dm_wdata, inputRD2);
        exp_regw   = 1'b0;
        exp_memreg = 1'b0;
        exp_err    = 1'b0;
        chk_wb({tag, ".bubble"});
      end
      if (c > 0 && dm_ack) got_data = dm_rdata;
      @(negedge clk);
    end
    dm_ack = 1'b0;
    if (is_mis || (is_mem && !acked)) begin
      exp_regw   = 1'b0;
      exp_memreg = 1'b0;
      exp_err    = 1'b1;
    end else begin
      exp_regw   = INRegWRITE;
      exp_memreg = INMemREG;
      exp_alu    = inputAddrst;
      exp_mux    = inputmux;
      exp_err    = 1'b0;
      if (is_mem) exp_rd = got_data;
    end
    #1;
    chk_wb({tag, ".wb"});
  endtask

  initial begin
    int          kind, sel, ack_k;
    logic [31:0] addr, r;
    rst      = 1'b1;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    exp_regw = 1'b0; exp_memreg = 1'b0; exp_err = 1'b0;
    exp_rd = '0; exp_alu = '0; exp_mux = '0;
    chk_wb("reset");
    chk1("reset.dm_req", dm_req, 1'b0);
    chk1("reset.stall", stall, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ALU op at 0x10 into r5
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h10, 32'h0, 5'd5);
    run_txn("alu", 0, '0);
    // Load from 0x40, ack on the fourth BUSY cycle
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 5'd7);
    run_txn("load", 3, 32'hDEADBEEF);
    chk32("load.rd_value", outputRD, 32'hDEADBEEF);
    // Store to 0x44, immediate ack
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h44, 32'h1234, 5'd0);
    run_txn("store", 0, 32'h5555AAAA);
    // Load with no ack: abort
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 5'd3);
    run_txn("timeout", TIMEOUT + 4, '0);
    // Ack on the last allowed cycle wins over the timeout
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h84, 32'h0, 5'd9);
    run_txn("ack_last", TIMEOUT - 1, 32'h0BADF00D);
    // Misaligned load
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h42, 32'h0, 5'd4);
    run_txn("misalign", 0, '0);
    // Taken branch
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h8, 32'h0, 5'd0);
    run_txn("branch", 0, '0);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 4);
      r    = $urandom;
      addr = r & 32'hFFFF_FFFC;
      if (kind == 3 && r[1:0] == 2'b00) r[0] = 1'b1;
      sel = $urandom_range(0, 9);
      if (sel < 7)       ack_k = $urandom_range(0, 4);
      else if (sel == 7) ack_k = TIMEOUT - 1;
      else if (sel == 8) ack_k = TIMEOUT;
      else               ack_k = $urandom_range(5, TIMEOUT - 2);
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'($urandom),
             $urandom, addr, $urandom, 5'($urandom));
      case (kind)
        1: INMemRead = 1'b1;
        2: INMemWRITE = 1'b1;
        3: begin
          inputAddrst = r;
          INMemRead   = 1'($urandom);
          INMemWRITE  = ~INMemRead | 1'($urandom);
        end
        4: begin INMemRead = 1'b1; INMemWRITE = 1'b1; end
        default: ;
      endcase
      run_txn("rand", ack_k, $urandom);
    end

    // Reset in the second BUSY cycle of a load
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hABCD, 32'h0, 5'd6);
    run_txn("pre_rst", 0, '0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 5'd2);
    dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    #1;
    exp_regw = 1'b0; exp_memreg = 1'b0; exp_err = 1'b0;
    exp_rd = '0; exp_alu = '0; exp_mux = '0;
    chk_wb("midrst");
    chk1("midrst.dm_req", dm_req, 1'b0);
    chk1("midrst.stall", stall, 1'b0);
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFEF00D;
    #1;
    chk1("late_ack.dm_req", dm_req, 1'b0);
    chk1("late_ack.stall", stall, 1'b0);
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    chk_wb("late_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles to wait for dm_ack before aborting.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 INMemREG, INRegWRITE, INBranch, INMemWRITE, INMemRead  in  1 each  control bits from the EX/MEM register.
REQ-005 inputAdd  in  32  branch target; inputAddrst  in  32  ALU result / memory address; inputRD2  in  32  store data; Z_flag  in  1; inputmux  in  5  destination register.
REQ-006 dm_req, dm_we  out  1 each; dm_addr, dm_wdata  out  32 each; dm_rdata  in  32; dm_ack  in  1  data-memory handshake.
REQ-007 stall  out  1  freeze request to PC, IF/ID, ID/EX and EX/MEM.
REQ-008 PCSrc  out  1  branch taken; branch_target  out  32  PC value to load.
REQ-009 OTMemREG, OTRegWRITE  out  1 each; outputRD  out  32  load data; outputAlu  out  32; outputmux  out  5  MEM/WB register outputs.
REQ-010 mem_err  out  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-011 PCSrc SHALL equal INBranch AND Z_flag combinationally, and branch_target SHALL equal inputAdd.
REQ-012 An access is a memory operation when INMemRead or INMemWRITE is 1 and inputAddrst[1:0] is 00; INMemRead and INMemWRITE both 1 SHALL be treated as a write.
REQ-013 FSM states SHALL be IDLE and BUSY.
REQ-014 IDLE with a memory operation SHALL assert stall combinationally and SHALL go to BUSY at the next edge.
REQ-015 IDLE with no memory operation SHALL keep stall at 0 and SHALL make the MEM/WB register capture the inputs at the next edge, giving one-cycle latency.
REQ-016 In BUSY, dm_req SHALL be 1, dm_we SHALL equal INMemWRITE, dm_addr SHALL equal inputAddrst and dm_wdata SHALL equal inputRD2, all held stable until ack or abort.
REQ-017 In BUSY, stall SHALL be NOT dm_ack.
REQ-018 On the edge where dm_ack=1 in BUSY, MEM/WB SHALL capture dm_rdata into outputRD, together with the control bits, inputAddrst and inputmux, and the FSM SHALL return to IDLE; the minimum load/store latency is 2 cycles.
REQ-019 dm_ack seen in IDLE SHALL be ignored.
REQ-020 A 4-bit BUSY counter SHALL clear on entry to BUSY.
REQ-021 If the counter reaches TIMEOUT-1 without dm_ack, the next edge SHALL abort: return to IDLE, capture a bubble, and pulse mem_err.
REQ-022 dm_ack arriving in the cycle where the counter equals TIMEOUT-1 SHALL win over the timeout.
REQ-023 A misaligned MemRead or MemWRITE SHALL issue no dm_req and no stall, SHALL pulse mem_err for one cycle, and SHALL capture a bubble.
REQ-024 Every edge with stall=1 SHALL load a bubble into MEM/WB: OTRegWRITE=0 and OTMemREG=0, with data outputs holding their previous values.
REQ-025 Upstream SHALL hold all IN* inputs stable while stall=1; the block SHALL NOT latch them internally.

Reset
REQ-026 rst=1 at an edge SHALL set state=IDLE, counter=0, and all registered outputs (OT*, outputRD, outputAlu, outputmux, mem_err) to 0.
REQ-027 dm_req SHALL be 0 in the cycle after a reset edge, including a reset taken mid-access; a dm_ack arriving later SHALL be ignored.
REQ-028 The block SHALL NOT capture a pending access during reset.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=0, BUSY=1) and the TIMEOUT default.
REQ-030 The MEM/WB register SHALL be a sub-module, buffer4, with a bubble input and a synchronous reset.

Verification
REQ-031 ALU op (RegWRITE=1, Addrst=0x10, mux=5) -> next cycle OTRegWRITE=1, outputAlu=0x10, outputmux=5, stall never 1.
REQ-032 Load from 0x40, dm_ack 3 cycles after dm_req rises, rdata=0xDEADBEEF -> stall for 4 cycles, outputRD=0xDEADBEEF, bubbles in between.
REQ-033 Store to 0x44 with data 0x1234, immediate ack -> dm_we=1, dm_wdata=0x1234, dm_req 1 cycle, OTRegWRITE=0.
REQ-034 Load with no ack -> abort after 16 BUSY cycles, mem_err pulse, OTRegWRITE=0, stall falls.
REQ-035 Load at 0x42 -> no dm_req, mem_err=1 for 1 cycle, bubble captured; separately, Branch=1 with Z=1 and target 0x100 -> PCSrc=1 and branch_target=0x100 in the same cycle.
REQ-036 rst asserted in the 2nd BUSY cycle -> dm_req=0 next cycle, all outputs 0, late dm_ack ignored.
